// File: rtl/mem_access_unit_if.sv
// Bus-side handshake between the memory access unit and its memory responder.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_byte_en,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_byte_en,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: converts load/store codes into a single word-aligned
// req/ack bus transaction, stalls the pipeline meanwhile, and extends load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               access, is_store, req_ok;
  logic [3:0]         req_be;
  logic [31:0]        req_wdata;
  logic               stall_c, misaligned_c, ack_hit, abort;
  logic [2:0]         funct3_p0;
  logic [1:0]         lane_p0;

  // Select and extend the addressed lane(s) of the returned read word.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'h0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'h0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign cnt_inc = cnt + 1'b1;

  // Decode the incoming code: alignment check, lane mask and replicated write data.
  always_comb begin
    is_store  = mem_write[2];
    access    = mem_write[2] | mem_read[3];
    req_ok    = 1'b0;
    req_be    = 4'b0000;
    req_wdata = 32'h0;
    if (is_store) begin
      case (mem_write[1:0])
        2'b00: begin
          req_ok    = 1'b1;
          req_be    = 4'b0001 << address[1:0];
          req_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          req_ok    = ~address[0];
          req_be    = 4'b0011 << address[1:0];
          req_wdata = {2{store_data[15:0]}};
        end
        2'b10: begin
          req_ok    = (address[1:0] == 2'b00);
          req_be    = 4'b1111;
          req_wdata = store_data;
        end
        default: req_ok = 1'b0;
      endcase
    end else begin
      case (mem_read[2:0])
        3'b000, 3'b100: begin
          req_ok = 1'b1;
          req_be = 4'b0001 << address[1:0];
        end
        3'b001, 3'b101: begin
          req_ok = ~address[0];
          req_be = 4'b0011 << address[1:0];
        end
        3'b010: begin
          req_ok = (address[1:0] == 2'b00);
          req_be = 4'b1111;
        end
        default: req_ok = 1'b0;
      endcase
    end
  end

  // Next-state logic with combinational stall/misaligned; ack wins over a same-cycle timeout.
  always_comb begin
    state_next   = state;
    stall_c      = 1'b0;
    misaligned_c = 1'b0;
    ack_hit      = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (req_ok) begin
            stall_c    = 1'b1;
            state_next = ACCESS;
          end else begin
            misaligned_c = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (bus.bus_ack) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign stall      = stall_c & reset;
  assign misaligned = misaligned_c & reset;

  // State register, bus request/address/data registers, counter and load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.bus_req     <= 1'b0;
      bus.bus_we      <= 1'b0;
      bus.bus_addr    <= 32'h0;
      bus.bus_wdata   <= 32'h0;
      bus.bus_byte_en <= 4'b0000;
      load_data       <= 32'h0;
      bus_error       <= 1'b0;
    end else begin
      state     <= state_next;
      bus_error <= abort;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (access) begin
            if (req_ok) begin
              bus.bus_req     <= 1'b1;
              bus.bus_we      <= is_store;
              bus.bus_addr    <= {address[31:2], 2'b00};
              bus.bus_wdata   <= req_wdata;
              bus.bus_byte_en <= req_be;
            end else begin
              load_data <= 32'h0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt_inc;
          if (ack_hit) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) begin
              load_data <= extend_load(funct3_p0, lane_p0, bus.bus_rdata);
            end
          end else if (abort) begin
            bus.bus_req <= 1'b0;
            load_data   <= 32'h0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Remember load type and byte lane for the response; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && access && req_ok) begin
      funct3_p0 <= mem_read[2:0];
      lane_p0   <= address[1:0];
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected transactions are queued when an
// instruction is driven and retired against the DUT in its DONE cycle.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall, misaligned, bus_error;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic [3:0]  be;
    logic        we;
    logic        err;
    int          reqc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] ld_model = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    mem_read   = 4'h0;
    mem_write  = 3'h0;
    address    = 32'h0;
    store_data = 32'h0;
  endtask

  // Aligned access; called at posedge+1 of an IDLE cycle, returns at posedge+1 after DONE.
  task automatic run_op(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int dly);
    exp_t        e;
    exp_t        r;
    int          reqc;
    logic [1:0]  off;
    logic [31:0] sh;
    off     = a[1:0];
    e.addr  = {a[31:2], 2'b00};
    e.we    = wr[2];
    e.wdata = 32'h0;
    e.be    = 4'h0;
    e.err   = 1'b0;
    e.ld    = ld_model;
    if (wr[2]) begin
      case (wr[1:0])
        2'b00:   begin e.be = 4'b0001 << off; e.wdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]}; end
        2'b01:   begin e.be = off[1] ? 4'b1100 : 4'b0011; e.wdata = {sd[15:0], sd[15:0]}; end
        default: begin e.be = 4'hF; e.wdata = sd; end
      endcase
    end else begin
      sh = rdata >> {off, 3'b000};
      case (rd[2:0])
        3'b000:  begin e.be = 4'b0001 << off; e.ld = {{24{sh[7]}}, sh[7:0]}; end
        3'b100:  begin e.be = 4'b0001 << off; e.ld = {24'h0, sh[7:0]}; end
        3'b001:  begin e.be = off[1] ? 4'b1100 : 4'b0011; e.ld = {{16{sh[15]}}, sh[15:0]}; end
        3'b101:  begin e.be = off[1] ? 4'b1100 : 4'b0011; e.ld = {16'h0, sh[15:0]}; end
        default: begin e.be = 4'hF; e.ld = rdata; end
      endcase
    end
    if (dly < 0) begin e.err = 1'b1; e.ld = 32'h0; e.reqc = TMO; end
    else e.reqc = dly + 1;
    ld_model = e.ld;
    sb.push_back(e);

    mem_read      = rd;
    mem_write     = wr;
    address       = a;
    store_data    = sd;
    bus.bus_rdata = rdata;
    @(negedge clk);
    chk({tag, "/stall_issue"}, {31'h0, stall}, 32'd1);
    chk({tag, "/req_issue"}, {31'h0, bus.bus_req}, 32'd0);
    chk({tag, "/err_issue"}, {31'h0, bus_error}, 32'd0);
    @(posedge clk); #1;
    reqc = 0;
    for (int c = 0; c < 40; c++) begin
      bus.bus_ack = (dly >= 0) && (reqc == dly);
      @(negedge clk);
      if (!bus.bus_req) break;
      chk({tag, "/addr"}, bus.bus_addr, sb[0].addr);
      chk({tag, "/be"}, {28'h0, bus.bus_byte_en}, {28'h0, sb[0].be});
      chk({tag, "/we"}, {31'h0, bus.bus_we}, {31'h0, sb[0].we});
      if (sb[0].we) chk({tag, "/wdata"}, bus.bus_wdata, sb[0].wdata);
      chk({tag, "/stall_acc"}, {31'h0, stall}, 32'd1);
      reqc++;
      @(posedge clk); #1;
    end
    bus.bus_ack = 1'b0;
    r = sb.pop_front();
    chk({tag, "/req_cycles"}, reqc, r.reqc);
    chk({tag, "/req_done"}, {31'h0, bus.bus_req}, 32'd0);
    chk({tag, "/stall_done"}, {31'h0, stall}, 32'd0);
    chk({tag, "/load_data"}, load_data, r.ld);
    chk({tag, "/bus_error"}, {31'h0, bus_error}, {31'h0, r.err});
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Misaligned or undefined access: no request, one-cycle misaligned pulse.
  task automatic run_bad(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] a);
    mem_read  = rd;
    mem_write = wr;
    address   = a;
    @(negedge clk);
    chk({tag, "/mis_pulse"}, {31'h0, misaligned}, 32'd1);
    chk({tag, "/stall"}, {31'h0, stall}, 32'd0);
    chk({tag, "/req"}, {31'h0, bus.bus_req}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    ld_model = 32'h0;
    @(negedge clk);
    chk({tag, "/mis_clear"}, {31'h0, misaligned}, 32'd0);
    chk({tag, "/req_after"}, {31'h0, bus.bus_req}, 32'd0);
    chk({tag, "/load_zero"}, load_data, ld_model);
    @(posedge clk); #1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h0;
    idle_inputs();
    #3;
    chk("rst/bus_req", {31'h0, bus.bus_req}, 32'd0);
    chk("rst/bus_we", {31'h0, bus.bus_we}, 32'd0);
    chk("rst/stall", {31'h0, stall}, 32'd0);
    chk("rst/misaligned", {31'h0, misaligned}, 32'd0);
    chk("rst/bus_error", {31'h0, bus_error}, 32'd0);
    chk("rst/load_data", load_data, 32'h0);
    chk("rst/bus_addr", bus.bus_addr, 32'h0);
    chk("rst/bus_wdata", bus.bus_wdata, 32'h0);
    chk("rst/byte_en", {28'h0, bus.bus_byte_en}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("lw100", 4'b1010, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_op("lb103", 4'b1000, 3'b000, 32'h103, 32'h0, 32'h80FF0102, 0);
    run_op("lbu103", 4'b1100, 3'b000, 32'h103, 32'h0, 32'h80FF0102, 1);
    run_op("lh102", 4'b1001, 3'b000, 32'h102, 32'h0, 32'h80FF0102, 0);
    run_op("lhu100", 4'b1101, 3'b000, 32'h100, 32'h0, 32'h80FF8102, 0);
    run_op("lb101", 4'b1000, 3'b000, 32'h101, 32'h0, 32'h1234F678, 0);
    run_op("sh202", 4'b0000, 3'b101, 32'h202, 32'h1234ABCD, 32'h0, 2);
    run_op("sb101", 4'b0000, 3'b100, 32'h101, 32'h00000055, 32'h0, 0);
    run_op("both", 4'b1010, 3'b110, 32'h204, 32'h0BADF00D, 32'h11111111, 0);

    run_bad("lw101", 4'b1010, 3'b000, 32'h101);
    run_bad("sh203", 4'b0000, 3'b101, 32'h203);
    run_bad("f3_011", 4'b1011, 3'b000, 32'h0);
    run_bad("sz_11", 4'b0000, 3'b111, 32'h0);

    run_op("lw_tmo", 4'b1010, 3'b000, 32'h300, 32'h0, 32'h55555555, -1);
    // Late ack while no request is outstanding must be ignored.
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late_ack/req", {31'h0, bus.bus_req}, 32'd0);
    chk("late_ack/stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack/load", load_data, 32'h0);
    chk("late_ack/err", {31'h0, bus_error}, 32'd0);
    @(posedge clk); #1;
    run_op("lw_after", 4'b1010, 3'b000, 32'h304, 32'h0, 32'hA5A5A5A5, 0);

    // Reset in the second ACCESS cycle of a delayed store.
    mem_write  = 3'b110;
    address    = 32'h400;
    store_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_mid/stall_issue", {31'h0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid/req_acc1", {31'h0, bus.bus_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_mid/req", {31'h0, bus.bus_req}, 32'd0);
    chk("rst_mid/stall", {31'h0, stall}, 32'd0);
    chk("rst_mid/err", {31'h0, bus_error}, 32'd0);
    chk("rst_mid/addr", bus.bus_addr, 32'h0);
    idle_inputs();
    ld_model = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid/idle_stall", {31'h0, stall}, 32'd0);
    chk("rst_mid/idle_err", {31'h0, bus_error}, 32'd0);
    @(posedge clk); #1;
    run_op("sw_b2b", 4'b0000, 3'b110, 32'h400, 32'hCAFEF00D, 32'h0, 3);
    run_op("lw_b2b", 4'b1010, 3'b000, 32'h400, 32'h0, 32'hCAFEF00D, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
